rd_burst_arbiter: RTL and testbench

Shares the single external read-burst port among several burst-read requesters such as input caches, each fetching 64-beat (512 B) lines. Grants one complete burst at a time, forwards the requester's start address to memory, steers the per-beat acknowledge back to the granted requester, and broadcasts read data to all requesters. Sits between the requester instances and the AXI read master.

---
 rtl/rdarb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/rd_burst_arbiter.sv | 114 +++++++++++
 tb/tb_rd_burst_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rdarb_pkg.sv
// Shared types and defaults for the read-burst arbiter.
// Arbitration mode is selected by the RDARB_RR_EN macro (see rd_burst_arbiter).
package rdarb_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    WaitAck = 2'd1,
    Burst   = 2'd2
  } state_e;

  localparam int unsigned DefNtfr   = 64;
  localparam int unsigned DefAw     = 24;
  localparam int unsigned BeatWidth = 64;

  // Beat counter width: must hold NTFR-1 without wrapping inside a burst.
  function automatic int unsigned bcnt_width(input int unsigned ntfr);
    return $clog2(ntfr) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: with RDARB_RR_EN the search starts one past ptr,
// otherwise it is a plain lowest-index-wins priority encoder with no ptr port.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifdef RDARB_RR_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic [IW-1:0]   idx,
  output logic            valid
);

`ifdef RDARB_RR_EN
  int unsigned cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    // k = NREQ wraps back to ptr itself, so it is searched last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end
`else
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = IW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/rd_burst_arbiter.sv
// Shares one external read-burst port among NREQ requesters, one whole burst at a time.
// Define RDARB_RR_EN for round-robin arbitration; undefined gives fixed priority.
module rd_burst_arbiter
  import rdarb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NTFR = DefNtfr,
  parameter int unsigned AW   = DefAw
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      rreq,
  input  logic [NREQ*AW-1:0]   radr,
  output logic [NREQ-1:0]      rack,
  output logic [BeatWidth-1:0] rdata,
  output logic                 mreq,
  input  logic                 mack,
  output logic [AW-1:0]        madr,
  input  logic [BeatWidth-1:0] mdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = bcnt_width(NTFR);

  state_e          state_q;
  logic [BW-1:0]   bcnt_q;
  logic            mreq_q;
  logic [AW-1:0]   madr_q;
  logic [NREQ-1:0] gnt_q;

  logic [IW-1:0]   win;
  logic            win_valid;
  logic [AW-1:0]   win_adr;

`ifdef RDARB_RR_EN
  logic [IW-1:0]   last_q;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (rreq),
`ifdef RDARB_RR_EN
    .ptr   (last_q),
`endif
    .idx   (win),
    .valid (win_valid)
  );

  always_comb begin
    win_adr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == win) win_adr = radr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Idle;
      bcnt_q  <= '0;
      mreq_q  <= 1'b0;
      madr_q  <= '0;
      gnt_q   <= '0;
`ifdef RDARB_RR_EN
      // Pointer at the last index makes requester 0 the first winner.
      last_q  <= IW'(NREQ - 1);
`endif
    end else begin
      unique case (state_q)
        Idle: begin
          // rreq is only looked at here, so a stale high level mid-burst is harmless.
          if (win_valid) begin
            madr_q  <= win_adr;
            mreq_q  <= 1'b1;
            gnt_q   <= NREQ'(1) << win;
            state_q <= WaitAck;
`ifdef RDARB_RR_EN
            last_q  <= win;
`endif
          end
        end
        WaitAck: begin
          if (mack) begin
            mreq_q  <= 1'b0;
            bcnt_q  <= BW'(1);
            state_q <= Burst;
          end
        end
        Burst: begin
          if (mack) begin
            bcnt_q <= bcnt_q + BW'(1);
            if (bcnt_q == BW'(NTFR - 1)) begin
              gnt_q   <= '0;
              state_q <= Idle;
            end
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // gnt_q is zero outside a burst, so stray acks in Idle never reach a requester.
  assign rack  = mack ? gnt_q : '0;
  assign rdata = mdata;
  assign mreq  = mreq_q;
  assign madr  = madr_q;
  assign gnt   = gnt_q;
  assign busy  = (state_q != Idle);

endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Directed bench for rd_burst_arbiter; the arbitration-order step follows RDARB_RR_EN.
module tb_rd_burst_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NTFR = 64;
  localparam int unsigned AW   = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     rreq;
  logic [NREQ*AW-1:0]  radr;
  logic [NREQ-1:0]     rack;
  logic [63:0]         rdata;
  logic                mreq;
  logic                mack;
  logic [AW-1:0]       madr;
  logic [63:0]         mdata;
  logic [NREQ-1:0]     gnt;
  logic                busy;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] adrs [NREQ];
  int            seq  [$];

  always #5 clk = ~clk;

  rd_burst_arbiter #(
    .NREQ (NREQ),
    .NTFR (NTFR),
    .AW   (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rreq  (rreq),
    .radr  (radr),
    .rack  (rack),
    .rdata (rdata),
    .mreq  (mreq),
    .mack  (mack),
    .madr  (madr),
    .mdata (mdata),
    .gnt   (gnt),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the grant edge; leaves just after the edge that ends the burst.
  task automatic burst(input int g, input bit drop);
    int              cg;
    int              co;
    logic [NREQ-1:0] oh;
    oh = 4'b0001 << g;
    chk($sformatf("grant%0d_mreq", g), {63'd0, mreq}, 64'd1);
    chk($sformatf("grant%0d_gnt", g), {60'd0, gnt}, {60'd0, oh});
    chk($sformatf("grant%0d_madr", g), {40'd0, madr}, {40'd0, adrs[g]});
    chk($sformatf("grant%0d_busy", g), {63'd0, busy}, 64'd1);
    mack = 1'b0;
    tick();
    chk($sformatf("grant%0d_mreq_held", g), {63'd0, mreq}, 64'd1);
    cg = 0;
    co = 0;
    for (int b = 0; b < int'(NTFR); b++) begin
      mack  = 1'b1;
      mdata = {32'(g), 32'(b)} ^ 64'hA5A5_0000_5A5A_0000;
      #1;
      cg += int'(rack[g]);
      co += $countones(rack & ~oh);
      if (b == 5)
        chk($sformatf("burst%0d_rdata", g), rdata, {32'(g), 32'(5)} ^ 64'hA5A5_0000_5A5A_0000);
      if (b == int'(NTFR) - 1)
        chk($sformatf("burst%0d_busy_last", g), {63'd0, busy}, 64'd1);
      tick();
      if (b == 0) begin
        chk($sformatf("burst%0d_mreq_fall", g), {63'd0, mreq}, 64'd0);
        if (drop) rreq[g] = 1'b0;
      end
    end
    mack = 1'b0;
    chk($sformatf("burst%0d_rack_own", g), 64'(cg), 64'(NTFR));
    chk($sformatf("burst%0d_rack_other", g), 64'(co), 64'd0);
    chk($sformatf("burst%0d_gnt_end", g), {60'd0, gnt}, 64'd0);
    chk($sformatf("burst%0d_busy_end", g), {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    adrs[0] = 24'h100000;
    adrs[1] = 24'h200040;
    adrs[2] = 24'h012200;
    adrs[3] = 24'h3fffc0;
    rst   = 1'b1;
    rreq  = '0;
    radr  = '0;
    mack  = 1'b0;
    mdata = '0;
    for (int i = 0; i < int'(NREQ); i++) radr[i*AW +: AW] = adrs[i];

    // Reset state
    tick();
    tick();
    chk("rst_mreq", {63'd0, mreq}, 64'd0);
    chk("rst_madr", {40'd0, madr}, 64'd0);
    chk("rst_gnt", {60'd0, gnt}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    mack = 1'b1;
    #1;
    chk("rst_rack", {60'd0, rack}, 64'd0);
    mack = 1'b0;
    rst  = 1'b0;

    // Stray acks while idle
    tick();
    mack = 1'b1;
    #1;
    chk("stray_rack", {60'd0, rack}, 64'd0);
    tick();
    chk("stray_busy", {63'd0, busy}, 64'd0);
    chk("stray_mreq", {63'd0, mreq}, 64'd0);
    chk("stray_gnt", {60'd0, gnt}, 64'd0);
    mack = 1'b0;

    // Single requester 2, dropping rreq one cycle after its first rack
    rreq = 4'b0100;
    tick();
    burst(2, 1'b1);
    tick();
    chk("stale_mreq", {63'd0, mreq}, 64'd0);
    chk("stale_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("stale_gnt", {60'd0, gnt}, 64'd0);

    // All four requesting from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef RDARB_RR_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 0, 0};
`endif
    rreq = 4'b1111;
    tick();
    for (int k = 0; k < seq.size(); k++) begin
      burst(seq[k], 1'b0);
      if (k == seq.size() - 1) rreq = '0;
      tick();
    end
    chk("all_done_mreq", {63'd0, mreq}, 64'd0);
    chk("all_done_busy", {63'd0, busy}, 64'd0);

    // Reset during beat 30 of a burst to requester 3
    rreq = 4'b1000;
    tick();
    chk("rst30_gnt_pre", {60'd0, gnt}, 64'h8);
    mack = 1'b1;
    for (int b = 0; b < 29; b++) tick();
    rreq = 4'b0000;
    chk("rst30_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    chk("rst30_gnt", {60'd0, gnt}, 64'd0);
    chk("rst30_mreq", {63'd0, mreq}, 64'd0);
    chk("rst30_busy", {63'd0, busy}, 64'd0);
    chk("rst30_rack", {60'd0, rack}, 64'd0);
    rst  = 1'b0;
    mack = 1'b0;
    rreq = 4'b1001;
    tick();
    burst(0, 1'b1);
    rreq = '0;
    tick();
    chk("final_busy", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
